// File: rtl/countdown_stream_if.sv
// Index stream handshake between countdown_stream and its consumer.
interface countdown_stream_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 validOut;
  logic [CNT_WIDTH-1:0] cntOut;
  logic                 lastOut;
  logic                 readyIn;

  modport master (output validOut, output cntOut, output lastOut, input readyIn);
  modport slave  (input validOut, input cntOut, input lastOut, output readyIn);
endinterface

// File: rtl/countdown_stream.sv
// Loadable down-counter emitting N-1..0 over a valid/ready stream,
// with busy status and a one-cycle completion pulse.
module countdown_stream #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 startIn,
  input  logic [CNT_WIDTH-1:0] startValIn,
  input  logic                 abortIn,
  output logic                 busyOut,
  output logic                 doneOut,
  countdown_stream_if.master   strm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                state;
  logic                 validQ;
  logic [CNT_WIDTH-1:0] cntQ;

  wire xfer = validQ && strm.readyIn;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state   <= IDLE;
      validQ  <= 1'b0;
      cntQ    <= '0;
      busyOut <= 1'b0;
      doneOut <= 1'b0;
    end else begin
      doneOut <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startIn) begin
            if (startValIn == '0) begin
              state   <= DONE;
              doneOut <= 1'b1;
            end else begin
              state   <= RUN;
              cntQ    <= startValIn - CNT_WIDTH'(1);
              validQ  <= 1'b1;
              busyOut <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over a same-cycle transfer and suppresses the done pulse.
          if (abortIn) begin
            state   <= IDLE;
            validQ  <= 1'b0;
            busyOut <= 1'b0;
          end else if (xfer) begin
            if (cntQ == '0) begin
              state   <= DONE;
              validQ  <= 1'b0;
              busyOut <= 1'b0;
              doneOut <= 1'b1;
            end else begin
              cntQ <= cntQ - CNT_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          validQ  <= 1'b0;
          busyOut <= 1'b0;
        end
      endcase
    end
  end

  assign strm.validOut = validQ;
  assign strm.cntOut   = cntQ;
  assign strm.lastOut  = validQ && (cntQ == '0);

endmodule

// File: tb/tb_countdown_stream.sv
// Directed bench for countdown_stream: hand-computed per-cycle expectations.
module tb_countdown_stream;

  localparam int unsigned CNT_WIDTH = 8;

  logic                 clkIn;
  logic                 rstNIn;
  logic                 startIn;
  logic [CNT_WIDTH-1:0] startValIn;
  logic                 abortIn;
  logic                 busyOut;
  logic                 doneOut;

  int checkCnt = 0;
  int errCnt   = 0;

  countdown_stream_if #(.CNT_WIDTH(CNT_WIDTH)) strm ();

  countdown_stream #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clkIn      (clkIn),
    .rstNIn     (rstNIn),
    .startIn    (startIn),
    .startValIn (startValIn),
    .abortIn    (abortIn),
    .busyOut    (busyOut),
    .doneOut    (doneOut),
    .strm       (strm)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Observation point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic v, input logic [CNT_WIDTH-1:0] c,
                           input logic l, input logic b, input logic d);
    checkVal({tag, ".valid"}, 32'(strm.validOut), 32'(v));
    if (v) checkVal({tag, ".cnt"}, 32'(strm.cntOut), 32'(c));
    checkVal({tag, ".last"}, 32'(strm.lastOut), 32'(l));
    checkVal({tag, ".busy"}, 32'(busyOut), 32'(b));
    checkVal({tag, ".done"}, 32'(doneOut), 32'(d));
  endtask

  logic       rdyPat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] cntPat [7] = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0};

  initial begin
    rstNIn       = 1'b0;
    startIn      = 1'b0;
    startValIn   = '0;
    abortIn      = 1'b0;
    strm.readyIn = 1'b1;
    #12;
    expectOut("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkVal("reset.cnt", 32'(strm.cntOut), 32'd0);
    rstNIn = 1'b1;
    tick();

    // 1: N=3, always ready
    startIn = 1'b1; startValIn = 8'd3;
    tick();
    startIn = 1'b0;
    expectOut("t1.b0", 1'b1, 8'd2, 1'b0, 1'b1, 1'b0); tick();
    expectOut("t1.b1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0); tick();
    expectOut("t1.b2", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0); tick();
    expectOut("t1.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();
    expectOut("t1.id", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // 2: N=4 with stalls on RUN cycles 2-4
    startIn = 1'b1; startValIn = 8'd4;
    tick();
    startIn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strm.readyIn = rdyPat[i];
      expectOut($sformatf("t2.c%0d", i), 1'b1, cntPat[i], cntPat[i] == 8'd0, 1'b1, 1'b0);
      tick();
    end
    expectOut("t2.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();
    expectOut("t2.id", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // 3: N=0 goes straight to DONE
    startIn = 1'b1; startValIn = 8'd0;
    tick();
    startIn = 1'b0;
    expectOut("t3.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();
    expectOut("t3.id", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // 4: N=10, abort while cnt=6 and ready, then N=2
    startIn = 1'b1; startValIn = 8'd10;
    tick();
    startIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expectOut($sformatf("t4.c%0d", i), 1'b1, 8'(9 - i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    expectOut("t4.c6", 1'b1, 8'd6, 1'b0, 1'b1, 1'b0);
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    expectOut("t4.ab", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); tick();
    expectOut("t4.ab2", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    startIn = 1'b1; startValIn = 8'd2;
    tick();
    startIn = 1'b0;
    expectOut("t4.n1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0); tick();
    expectOut("t4.n0", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0); tick();
    expectOut("t4.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();

    // 5: async reset mid-run at cnt=3
    startIn = 1'b1; startValIn = 8'd5;
    tick();
    startIn = 1'b0;
    expectOut("t5.c4", 1'b1, 8'd4, 1'b0, 1'b1, 1'b0); tick();
    expectOut("t5.c3", 1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    #2 rstNIn = 1'b0;
    #1;
    expectOut("t5.rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkVal("t5.rst.cnt", 32'(strm.cntOut), 32'd0);
    #2 rstNIn = 1'b1;
    tick();
    expectOut("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    startIn = 1'b1; startValIn = 8'd1;
    tick();
    startIn = 1'b0;
    expectOut("t5.n0", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0); tick();
    expectOut("t5.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();

    // 6: N=255 with start held high throughout
    startIn = 1'b1; startValIn = 8'd255;
    tick();
    startValIn = 8'd7;
    for (int i = 0; i < 255; i++) begin
      checkVal($sformatf("t6.cnt%0d", i), 32'(strm.cntOut), 32'(254 - i));
      checkVal($sformatf("t6.val%0d", i), 32'(strm.validOut), 32'd1);
      if (i == 254 || i == 0) checkVal($sformatf("t6.last%0d", i), 32'(strm.lastOut), 32'(i == 254));
      tick();
    end
    expectOut("t6.dn", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1); tick();
    expectOut("t6.id", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); tick();
    expectOut("t6.rs", 1'b1, 8'd6, 1'b0, 1'b1, 1'b0);
    startIn = 1'b0; abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    expectOut("t6.ab", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule
